fft_ctrl_2: RTL and testbench

FFT_CTRL_2 -- requirements
Module: fft_ctrl_2

---
 rtl/fft_ctrl_2_pkg.sv | 21 ++
 rtl/fft_ctrl_2_dly.sv | 31 +++
 rtl/fft_ctrl_2.sv | 180 ++++++++++++++++++
 tb/tb_fft_ctrl_2.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_2_pkg.sv
// Shared definitions for the 16-point radix-2 FFT controller.
package fft_ctrl_2_pkg;

    localparam int unsigned FFT_N      = 16;
    localparam int unsigned FFT_STAGES = 4;
    localparam int unsigned FFT_BFLY   = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StFlush,
        StUnload
    } state_e;

    // Reverse the bit order of a 4-bit sample index.
    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft_ctrl_2_dly.sv
// Fixed-depth shift register used to align butterfly write strobes and addresses
// with the end of the RAM read plus butterfly latency.
module fft_ctrl_2_dly #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] pipe_q [Depth];

    // Shift one stage per cycle; reset discards everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < int'(Depth); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/fft_ctrl_2.sv
// Load / compute / unload sequencer for an in-place 16-point radix-2 FFT.
// Optional build macro FFT_CTRL_2_BITREV_EN: when defined, load addresses are the
// bit-reversed sample count; otherwise the source delivers samples pre-ordered.
module fft_ctrl_2
    import fft_ctrl_2_pkg::*;
#(
    parameter int unsigned BF_LAT = 1,
    parameter int unsigned AW     = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          ld_we_o,
    output logic [AW-1:0] ld_addr_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_m_o,
    output logic [AW-1:0] rd_addr_n_o,
    output logic [2:0]    tw_index_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_m_o,
    output logic [AW-1:0] wr_addr_n_o,
    output logic [1:0]    stage_o,
    output logic [AW-1:0] out_rd_addr_o,
    output logic          out_valid_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int unsigned FlW = (BF_LAT > 0) ? $clog2(BF_LAT + 1) : 1;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;     // load sample count / unload read count
    logic [2:0]     k_q, k_d;         // butterfly within stage
    logic [1:0]     s_q, s_d;         // stage
    logic [FlW-1:0] fl_q, fl_d;       // flush cycle count
    logic           ov_q, last_q, done_q;
    logic           unload_rd;

    logic [3:0] half, pos, grp, bf_m, bf_n;
    logic [2:0] tw;

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            k_q     <= '0;
            s_q     <= '0;
            fl_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            s_q     <= s_d;
            fl_q    <= fl_d;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        s_d        = s_q;
        fl_d       = fl_q;
        in_ready_o = 1'b0;
        ld_we_o    = 1'b0;
        rd_en_o    = 1'b0;
        unload_rd  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    ld_we_o = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'(FFT_N - 1)) begin
                        state_d = StRun;
                        k_d     = '0;
                        s_d     = '0;
                    end
                end
            end
            StRun: begin
                rd_en_o = 1'b1;
                k_d     = k_q + 3'd1;
                if (k_q == 3'(FFT_BFLY - 1)) begin
                    state_d = StFlush;
                    fl_d    = '0;
                end
            end
            StFlush: begin
                // Hold off the next stage until the last write of this one lands.
                fl_d = fl_q + FlW'(1);
                if (fl_q == FlW'(BF_LAT)) begin
                    if (s_q == 2'(FFT_STAGES - 1)) begin
                        state_d = StUnload;
                        cnt_d   = '0;
                    end else begin
                        state_d = StRun;
                        s_d     = s_q + 2'd1;
                        k_d     = '0;
                    end
                end
            end
            StUnload: begin
                unload_rd = 1'b1;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'(FFT_N - 1)) begin
                    state_d = StIdle;
                    s_d     = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Butterfly operand addresses and twiddle index for butterfly k of stage s.
    always_comb begin
        half = 4'd1 << s_q;
        pos  = {1'b0, k_q} & (half - 4'd1);
        grp  = {1'b0, k_q} >> s_q;
        bf_m = (grp << ({1'b0, s_q} + 3'd1)) + pos;
        bf_n = bf_m + half;
        tw   = pos[2:0] << (2'd3 - s_q);
    end

    // Address outputs are forced to zero whenever their strobe is inactive.
    always_comb begin
        rd_addr_m_o   = rd_en_o ? AW'(bf_m) : '0;
        rd_addr_n_o   = rd_en_o ? AW'(bf_n) : '0;
        tw_index_o    = rd_en_o ? tw : 3'd0;
        out_rd_addr_o = unload_rd ? AW'(cnt_q) : '0;
        ld_addr_o     = '0;
        if (in_ready_o) begin
`ifdef FFT_CTRL_2_BITREV_EN
            ld_addr_o = AW'(bitrev4(cnt_q));
`else
            ld_addr_o = AW'(cnt_q);
`endif
        end
    end

    // Unload data-valid and end-of-frame pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ov_q   <= 1'b0;
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ov_q   <= unload_rd;
            last_q <= unload_rd && (cnt_q == 4'(FFT_N - 1));
            done_q <= last_q;
        end
    end

    fft_ctrl_2_dly #(
        .Depth(1 + BF_LAT),
        .Width(1 + 2 * AW)
    ) u_wr_dly (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  ({rd_en_o, rd_addr_m_o, rd_addr_n_o}),
        .q_o  ({wr_en_o, wr_addr_m_o, wr_addr_n_o})
    );

    assign stage_o     = s_q;
    assign out_valid_o = ov_q;
    // Stay busy through the last data-valid cycle so busy drops with done.
    assign busy_o      = (state_q != StIdle) || ov_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_fft_ctrl_2.sv
// Self-checking bench for fft_ctrl_2: table of frame scenarios with random
// in_valid/start stimulus, checked against a behavioural model of the schedule.
`timescale 1ns/1ps
module tb_fft_ctrl_2;

    localparam int unsigned BF_LAT = 1;
    localparam int unsigned AW = 4;
    localparam int CMP_LAT = 8 + 1 + BF_LAT;

    logic clk = 1'b0;
    logic rst, start, in_valid;
    logic in_ready, ld_we, rd_en, wr_en, out_valid, busy, done;
    logic [AW-1:0] ld_addr, rd_m, rd_n, wr_m, wr_n, out_rd_addr;
    logic [2:0] tw_index;
    logic [1:0] stage;

    always #5 clk = ~clk;

    fft_ctrl_2 #(.BF_LAT(BF_LAT), .AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .ld_we_o(ld_we), .ld_addr_o(ld_addr),
        .rd_en_o(rd_en), .rd_addr_m_o(rd_m), .rd_addr_n_o(rd_n), .tw_index_o(tw_index),
        .wr_en_o(wr_en), .wr_addr_m_o(wr_m), .wr_addr_n_o(wr_n), .stage_o(stage),
        .out_rd_addr_o(out_rd_addr), .out_valid_o(out_valid), .busy_o(busy), .done_o(done)
    );

    typedef struct { int c; int a; int b; int t; } ev_t;
    typedef struct {
        string name; int dens; bit spam;
        int exp_ld; int exp_bf; int exp_ov; int exp_done;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int prev_oaddr = 0;
    ev_t ld_q[$], rd_q[$], wr_q[$], ov_q[$], done_q[$], exp_bf[$];
    vec_t vecs[5];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ld_we) ld_q.push_back('{cyc, int'(ld_addr), int'(in_valid), 0});
            if (rd_en) rd_q.push_back('{cyc, int'(rd_m), int'(rd_n), int'(tw_index)});
            if (wr_en) wr_q.push_back('{cyc, int'(wr_m), int'(wr_n), 0});
            if (out_valid) ov_q.push_back('{cyc, prev_oaddr, int'(busy), 0});
            if (done) done_q.push_back('{cyc, 0, int'(busy), 0});
        end
        prev_oaddr = int'(out_rd_addr);
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_ld(input int i);
        int r;
        r = i;
`ifdef FFT_CTRL_2_BITREV_EN
        r = 0;
        for (int b = 0; b < 4; b++) if (((i >> b) & 1) != 0) r = r | (1 << (3 - b));
`endif
        return r;
    endfunction

    // Butterfly schedule: per stage, blocks of 2*span, pairing j with j+span.
    task automatic build_model();
        int idx;
        for (int s = 0; s < 4; s++) begin
            int span;
            span = 1 << s;
            idx = 0;
            for (int base = 0; base < 16; base += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    exp_bf.push_back('{s * CMP_LAT + idx, base + j, base + j + span,
                                       j * (8 / span)});
                    idx++;
                end
            end
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_flags"}, longint'({in_ready, ld_we, rd_en, wr_en, out_valid, busy, done}), 0);
        chk({tag, "_addrs"}, longint'({ld_addr, rd_m, rd_n, tw_index, wr_m, wr_n, stage,
                                       out_rd_addr}), 0);
    endtask

    task automatic check_frame(input vec_t v);
        int t0;
        int n;
        chk({v.name, "_ld_count"}, ld_q.size(), v.exp_ld);
        for (int i = 0; i < ld_q.size() && i < 16; i++)
            chk({v.name, "_ld_addr"}, ld_q[i].a, exp_ld(i));
        chk({v.name, "_bf_count"}, rd_q.size(), v.exp_bf);
        chk({v.name, "_wr_count"}, wr_q.size(), v.exp_bf);
        if (rd_q.size() > 0) begin
            t0 = rd_q[0].c;
            if (ld_q.size() == 16) chk({v.name, "_run_start"}, t0, ld_q[15].c + 1);
            n = (rd_q.size() < exp_bf.size()) ? rd_q.size() : exp_bf.size();
            for (int i = 0; i < n; i++) begin
                chk({v.name, "_rd_cycle"}, rd_q[i].c - t0, exp_bf[i].c);
                chk({v.name, "_rd_m"}, rd_q[i].a, exp_bf[i].a);
                chk({v.name, "_rd_n"}, rd_q[i].b, exp_bf[i].b);
                chk({v.name, "_tw"}, rd_q[i].t, exp_bf[i].t);
            end
            n = (rd_q.size() < wr_q.size()) ? rd_q.size() : wr_q.size();
            for (int i = 0; i < n; i++) begin
                chk({v.name, "_wr_lat"}, wr_q[i].c - rd_q[i].c, 1 + BF_LAT);
                chk({v.name, "_wr_m"}, wr_q[i].a, rd_q[i].a);
                chk({v.name, "_wr_n"}, wr_q[i].b, rd_q[i].b);
            end
            if (ov_q.size() > 0) chk({v.name, "_compute_len"}, ov_q[0].c - t0, 4 * CMP_LAT + 1);
        end
        chk({v.name, "_ov_count"}, ov_q.size(), v.exp_ov);
        for (int i = 0; i < ov_q.size() && i < 16; i++) begin
            chk({v.name, "_ov_addr"}, ov_q[i].a, i);
            chk({v.name, "_ov_cycle"}, ov_q[i].c - ov_q[0].c, i);
        end
        chk({v.name, "_done_count"}, done_q.size(), v.exp_done);
        if (done_q.size() > 0 && ov_q.size() == 16) begin
            chk({v.name, "_done_cycle"}, done_q[0].c, ov_q[15].c + 1);
            chk({v.name, "_busy_at_done"}, done_q[0].b, 0);
            chk({v.name, "_busy_last_ov"}, ov_q[15].b, 1);
        end
    endtask

    // Caller sits just after a clock edge; start is presented in the current cycle.
    task automatic run_frame(input vec_t v);
        int n;
        ld_q.delete(); rd_q.delete(); wr_q.delete(); ov_q.delete(); done_q.delete();
        mon_en = 1'b1;
        start = 1'b1;
        in_valid = 1'b0;
        step();
        start = 1'b0;
        n = 0;
        while (done_q.size() == 0 && n < 400) begin
            if (v.dens < 0) in_valid = (n % 3 == 0);
            else in_valid = (int'($urandom_range(99)) < v.dens);
            start = v.spam && (ov_q.size() == 0) && ($urandom_range(3) == 0);
            step();
            n++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk({v.name, "_finished"}, longint'(done_q.size() > 0), 1);
        repeat (4) step();
        mon_en = 1'b0;
        check_frame(v);
    endtask

    initial begin
        int n;
        vecs[0] = '{"contig", 100, 1'b0, 16, 32, 16, 1};
        vecs[1] = '{"gap3", -1, 1'b0, 16, 32, 16, 1};
        vecs[2] = '{"rand50_spam", 50, 1'b1, 16, 32, 16, 1};
        vecs[3] = '{"rand30_spam", 30, 1'b1, 16, 32, 16, 1};
        vecs[4] = '{"rand80", 80, 1'b0, 16, 32, 16, 1};
        build_model();

        rst = 1'b1; start = 1'b0; in_valid = 1'b1;
        repeat (3) step();
        chk_outs_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Reset in the middle of stage 2, then restart right after reset releases.
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        n = 0;
        while (!(stage == 2'd2 && rd_en) && n < 200) begin
            step();
            n++;
        end
        chk("reach_stage2", longint'(stage == 2'd2 && rd_en), 1);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk_outs_zero("mid_run_rst");
        rst = 1'b0;
        run_frame('{"after_rst", 100, 1'b0, 16, 32, 16, 1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
